multi_lts_equalizer: RTL and testbench
======================================

MULTI_LTS_EQUALIZER -- requirements
Module: multi_lts_equalizer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter FFT_LEN, 64, subcarriers per LTS symbol (power of 2, 16..256).
REQ-003 Parameter DATA_W, 16, signed I/Q sample width.
REQ-004 Parameter N_LTS, 2, LTS symbols averaged per estimate (power of 2, 1..8).
REQ-005 Parameter POS_MASK, FFT_LEN bits, subcarrier k has reference +1 when bit FFT_LEN-1-k is set.
REQ-006 Parameter NEG_MASK, FFT_LEN bits, subcarrier k has reference -1 when bit FFT_LEN-1-k is set.
REQ-007 clk_in  input  1  clock.
REQ-008 rst_in  input  1  asynchronous active-low reset.
REQ-009 fft_axis_tvalid, fft_axis_tlast  input  1 each  input FFT beat valid / last beat of LTS block.
REQ-010 fft_re_axis_tdata, fft_im_axis_tdata  input  DATA_W signed  FFT bin.
REQ-011 fft_axis_tready  output  1  input accept.
REQ-012 csi_axis_tvalid, csi_axis_tlast  output  1 each  CSI beat valid / last non-null subcarrier.
REQ-013 csi_re_axis_tdata, csi_im_axis_tdata  output  DATA_W signed  channel estimate.
REQ-014 csi_axis_tuser  output  clog2(FFT_LEN)  subcarrier index k of current CSI beat.
REQ-015 csi_axis_tready  input  1  downstream accept.
REQ-016 sync_err_out  output  1  one-cycle pulse on framing error.

Function
REQ-017 Input beat accepted when fft_axis_tvalid && fft_axis_tready; fft_axis_tready = csi_axis_tready || !csi_axis_tvalid.
REQ-018 Counters k (0..FFT_LEN-1) and sym (0..N_LTS-1) advance only on accepted beats; k wraps to 0 and increments sym; sym wraps to 0 after N_LTS-1.
REQ-019 Per-subcarrier accumulator array, ACC_W = DATA_W+clog2(N_LTS)+1 bits for re and im; sym==0 loads sign-extended input, otherwise adds input.
REQ-020 On accepted beat with sym==N_LTS-1: sum = acc[k]+input; POS only -> result = sum>>>clog2(N_LTS); NEG only -> result = (-sum)>>>clog2(N_LTS); neither or both set -> null, no output beat.
REQ-021 Shift is arithmetic (floor); result saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-022 Non-null result registered to outputs one cycle after acceptance: csi_axis_tvalid=1, tuser=k, tlast=1 iff k equals highest non-null subcarrier index (derived from masks).
REQ-023 Output beat held stable while csi_axis_tvalid && !csi_axis_tready; cleared when consumed with no new result.
REQ-024 Accepted fft_axis_tlast with (k!=FFT_LEN-1 or sym!=N_LTS-1) -> sync_err_out pulses next cycle, k and sym return to 0, that beat produces no output, partial accumulation discarded.
REQ-025 Missing tlast at k=FFT_LEN-1, sym=N_LTS-1 is tolerated, no error.
REQ-026 N_LTS=1: no accumulation, output = sign-corrected input, saturated.

Reset
REQ-027 While rst_in low: csi_axis_tvalid=0, csi_axis_tlast=0, csi data=0, tuser=0, sync_err_out=0, k=0, sym=0; fft_axis_tready=1 after reset release.
REQ-028 Reset mid-frame discards all partial accumulation; first beat after release is k=0, sym=0.
REQ-029 Accumulator contents need no reset; never read before written in the current frame.

Verification
REQ-030 Reset: assert rst_in low mid-stream -> all outputs 0 immediately; after release first beat treated as k=0, sym=0.
REQ-031 Defaults, k=1 re 100/50, im -20/-40 -> tuser=1, re 75, im -30; k=2 re 100/50 -> re -75; k=0 -> no beat.
REQ-032 Rounding/saturation: k=1 re 1/0 -> 0; re -1/0 -> -1; k=2 re -32768/-32768 -> 32767.
REQ-033 Backpressure: hold csi_axis_tready=0 for 10 cycles during stream -> output held constant, fft_axis_tready=0, no beat lost or duplicated; full frame matches golden model.
REQ-034 Framing: tlast at k=10, sym=0 -> sync_err_out single pulse, no CSI for that frame, next full 2x64 frame produces correct estimates.
REQ-035 N_LTS=4 build: four symbols re 10,20,30,41 at k=1 -> re 25; last output beat has tlast=1 at highest non-null k.

Source files
------------

// File: rtl/multi_lts_equalizer_if.sv
// Stream bundle for the LTS channel estimator: FFT bins in, per-subcarrier CSI out.
interface multi_lts_equalizer_if #(
  parameter int DATA_W  = 16,
  parameter int FFT_LEN = 64
);
  localparam int IDX_W = $clog2(FFT_LEN);

  logic                     fft_axis_tvalid;
  logic                     fft_axis_tlast;
  logic                     fft_axis_tready;
  logic signed [DATA_W-1:0] fft_re_axis_tdata;
  logic signed [DATA_W-1:0] fft_im_axis_tdata;
  logic                     csi_axis_tvalid;
  logic                     csi_axis_tlast;
  logic                     csi_axis_tready;
  logic signed [DATA_W-1:0] csi_re_axis_tdata;
  logic signed [DATA_W-1:0] csi_im_axis_tdata;
  logic [IDX_W-1:0]         csi_axis_tuser;
  logic                     sync_err_out;

  modport master (
    output fft_axis_tvalid, fft_axis_tlast, fft_re_axis_tdata, fft_im_axis_tdata,
    input  fft_axis_tready,
    input  csi_axis_tvalid, csi_axis_tlast, csi_re_axis_tdata, csi_im_axis_tdata,
    input  csi_axis_tuser,
    output csi_axis_tready,
    input  sync_err_out
  );

  modport slave (
    input  fft_axis_tvalid, fft_axis_tlast, fft_re_axis_tdata, fft_im_axis_tdata,
    output fft_axis_tready,
    output csi_axis_tvalid, csi_axis_tlast, csi_re_axis_tdata, csi_im_axis_tdata,
    output csi_axis_tuser,
    input  csi_axis_tready,
    output sync_err_out
  );
endinterface

// File: rtl/multi_lts_equalizer.sv
// Averages N_LTS received LTS symbols per subcarrier and removes the known +/-1
// reference, emitting one CSI beat per non-null subcarrier.
module multi_lts_equalizer #(
  parameter int FFT_LEN = 64,
  parameter int DATA_W  = 16,
  parameter int N_LTS   = 2,
  // MSB is subcarrier 0; defaults are the 802.11a/g L-LTF in FFT bin order
  parameter logic [FFT_LEN-1:0] POS_MASK =
    64'b0_10011010100000110010101111_00000000000_11001101011111100110101111,
  parameter logic [FFT_LEN-1:0] NEG_MASK =
    64'b0_01100101011111001101010000_00000000000_00110010100000011001010000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  multi_lts_equalizer_if.slave  bus
);
  localparam int IDX_W = $clog2(FFT_LEN);
  localparam int SH    = $clog2(N_LTS);
  localparam int ACC_W = DATA_W + SH + 1;
  localparam int SYM_W = (N_LTS > 1) ? SH : 1;

  function automatic int last_nonnull();
    int r;
    r = 0;
    for (int i = 0; i < FFT_LEN; i++)
      if (POS_MASK[FFT_LEN-1-i] ^ NEG_MASK[FFT_LEN-1-i]) r = i;
    return r;
  endfunction

  localparam int LAST_K = last_nonnull();
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(SH+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  function automatic logic signed [DATA_W-1:0] scale_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] t;
    t = v >>> SH;
    if (t > SAT_HI) return SAT_HI[DATA_W-1:0];
    if (t < SAT_LO) return SAT_LO[DATA_W-1:0];
    return t[DATA_W-1:0];
  endfunction

  logic [IDX_W-1:0]         r_k;
  logic [SYM_W-1:0]         r_sym;
  logic signed [ACC_W-1:0]  r_acc_re [FFT_LEN];
  logic signed [ACC_W-1:0]  r_acc_im [FFT_LEN];
  logic                     r_csi_vld, r_csi_last, r_sync_err;
  logic signed [DATA_W-1:0] r_csi_re, r_csi_im;
  logic [IDX_W-1:0]         r_csi_k;

  logic                     w_rdy, w_acc, w_k_last, w_sym_last, w_err, w_pos, w_neg, w_emit;
  logic signed [ACC_W-1:0]  w_in_re, w_in_im, w_sum_re, w_sum_im, w_cor_re, w_cor_im;

  assign w_rdy      = bus.csi_axis_tready || !r_csi_vld;
  assign w_acc      = bus.fft_axis_tvalid && w_rdy;
  assign w_k_last   = (r_k == IDX_W'(FFT_LEN-1));
  assign w_sym_last = (r_sym == SYM_W'(N_LTS-1));
  assign w_err      = w_acc && bus.fft_axis_tlast && !(w_k_last && w_sym_last);

  // ~r_k == FFT_LEN-1-k because FFT_LEN is a power of two
  assign w_pos  = POS_MASK[~r_k];
  assign w_neg  = NEG_MASK[~r_k];
  assign w_emit = w_acc && !w_err && w_sym_last && (w_pos ^ w_neg);

  assign w_in_re  = ACC_W'(bus.fft_re_axis_tdata);
  assign w_in_im  = ACC_W'(bus.fft_im_axis_tdata);
  assign w_sum_re = (r_sym == '0) ? w_in_re : r_acc_re[r_k] + w_in_re;
  assign w_sum_im = (r_sym == '0) ? w_in_im : r_acc_im[r_k] + w_in_im;
  assign w_cor_re = w_neg ? -w_sum_re : w_sum_re;
  assign w_cor_im = w_neg ? -w_sum_im : w_sum_im;

  // Symbol 0 overwrites, so stale or aborted contents are never observed
  always_ff @(posedge clk_in) begin
    if (w_acc) begin
      r_acc_re[r_k] <= w_sum_re;
      r_acc_im[r_k] <= w_sum_im;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_k   <= '0;
      r_sym <= '0;
    end else if (w_acc) begin
      if (w_err) begin
        r_k   <= '0;
        r_sym <= '0;
      end else begin
        r_k <= r_k + IDX_W'(1);
        if (w_k_last) r_sym <= w_sym_last ? '0 : r_sym + SYM_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_csi_vld  <= 1'b0;
      r_csi_last <= 1'b0;
      r_csi_re   <= '0;
      r_csi_im   <= '0;
      r_csi_k    <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= w_err;
      if (w_emit) begin
        r_csi_vld  <= 1'b1;
        r_csi_last <= (r_k == IDX_W'(LAST_K));
        r_csi_re   <= scale_sat(w_cor_re);
        r_csi_im   <= scale_sat(w_cor_im);
        r_csi_k    <= r_k;
      end else if (bus.csi_axis_tready) begin
        r_csi_vld  <= 1'b0;
        r_csi_last <= 1'b0;
      end
    end
  end

  assign bus.fft_axis_tready   = w_rdy;
  assign bus.csi_axis_tvalid   = r_csi_vld;
  assign bus.csi_axis_tlast    = r_csi_last;
  assign bus.csi_re_axis_tdata = r_csi_re;
  assign bus.csi_im_axis_tdata = r_csi_im;
  assign bus.csi_axis_tuser    = r_csi_k;
  assign bus.sync_err_out      = r_sync_err;
endmodule

// File: tb/tb_multi_lts_equalizer.sv
// Randomized bench for the LTS equalizer: N_LTS=2 instance against a sample-sum
// reference model, plus an N_LTS=4 instance checked per subcarrier.
module tb_multi_lts_equalizer;
  localparam int FL = 64;
  localparam int DW = 16;
  localparam logic [FL-1:0] POS =
    64'b0_10011010100000110010101111_00000000000_11001101011111100110101111;
  localparam logic [FL-1:0] NEG =
    64'b0_01100101011111001101010000_00000000000_00110010100000011001010000;

  typedef struct { int k; int re; int im; bit last; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_lts_equalizer_if #(.DATA_W(DW), .FFT_LEN(FL)) b0 ();
  multi_lts_equalizer_if #(.DATA_W(DW), .FFT_LEN(FL)) b1 ();

  multi_lts_equalizer #(.FFT_LEN(FL), .DATA_W(DW), .N_LTS(2), .POS_MASK(POS), .NEG_MASK(NEG))
    dut0 (.clk_in(clk), .rst_in(rst_n), .bus(b0));
  multi_lts_equalizer #(.FFT_LEN(FL), .DATA_W(DW), .N_LTS(4), .POS_MASK(POS), .NEG_MASK(NEG))
    dut1 (.clk_in(clk), .rst_in(rst_n), .bus(b1));

  int   errs = 0, checks = 0;
  int   mk, msym, macc_re[FL], macc_im[FL];
  exp_t q[$];
  bit   err_evt = 0, prev_hold = 0;
  logic [39:0] p_snap;
  int   n_err, n_beats, seen[FL], got_re[FL], got_im[FL];
  int   hold_cnt = 0;
  bit   bp_rand = 0;
  int   last_k;
  int   fr_re[2][FL], fr_im[2][FL];
  int   r1_re[4][FL], r1_im[4][FL];
  int   seen1[FL], got1_re[FL], got1_im[FL], n_last1 = 0, last1_k = -1, n_err1 = 0;

  task automatic chk(string nm, logic signed [63:0] act, logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sgn(int k);
    if (POS[FL-1-k] && !NEG[FL-1-k]) return 1;
    if (NEG[FL-1-k] && !POS[FL-1-k]) return -1;
    return 0;
  endfunction

  // Mean of n symbols, rounded toward minus infinity, clipped to the sample range
  function automatic int expv(int sum, int n, int s);
    int v, r;
    v = s * sum;
    if (v >= 0) r = v / n;
    else        r = -((-v + n - 1) / n);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic model_reset();
    q.delete();
    mk = 0; msym = 0; err_evt = 0;
  endtask

  task automatic model_accept(int re, int im, bit last);
    exp_t e;
    if (last && !(mk == FL-1 && msym == 1)) begin
      err_evt = 1; mk = 0; msym = 0;
      return;
    end
    if (msym == 0) begin macc_re[mk] = re; macc_im[mk] = im; end
    else begin macc_re[mk] += re; macc_im[mk] += im; end
    if (msym == 1 && sgn(mk) != 0) begin
      e.k = mk; e.re = expv(macc_re[mk], 2, sgn(mk)); e.im = expv(macc_im[mk], 2, sgn(mk));
      e.last = (mk == last_k);
      q.push_back(e);
    end
    mk++;
    if (mk == FL) begin mk = 0; msym = (msym + 1) % 2; end
  endtask

  task automatic send0(int re, int im, bit last);
    bit acc;
    acc = 0;
    b0.fft_re_axis_tdata = 16'(re);
    b0.fft_im_axis_tdata = 16'(im);
    b0.fft_axis_tlast    = last;
    b0.fft_axis_tvalid   = 1'b1;
    for (int t = 0; t < 400 && !acc; t++) begin
      @(negedge clk); acc = b0.fft_axis_tready;
      @(posedge clk);
      if (acc) model_accept(re, im, last);
      #1;
    end
    b0.fft_axis_tvalid = 1'b0;
    if (!acc) chk("fft beat accepted within budget", acc, 1);
    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
  endtask

  task automatic fill_rand();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < FL; k++) begin fr_re[s][k] = rnd16(); fr_im[s][k] = rnd16(); end
  endtask

  task automatic send_frame(bit with_last);
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < FL; k++)
        send0(fr_re[s][k], fr_im[s][k], with_last && s == 1 && k == FL-1);
  endtask

  task automatic clear_seen();
    for (int k = 0; k < FL; k++) begin seen[k] = 0; got_re[k] = 0; got_im[k] = 0; end
    n_beats = 0; n_err = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || b0.csi_axis_tvalid) && t < 500) begin @(negedge clk); t++; end
    chk("csi drained within budget", t < 500, 1);
    @(posedge clk); #1;
  endtask

  task automatic reset_outputs_zero(string tag);
    chk({tag, " csi_tvalid"}, b0.csi_axis_tvalid, 0);
    chk({tag, " csi_tlast"}, b0.csi_axis_tlast, 0);
    chk({tag, " csi_re"}, b0.csi_re_axis_tdata, 0);
    chk({tag, " csi_im"}, b0.csi_im_axis_tdata, 0);
    chk({tag, " csi_tuser"}, b0.csi_axis_tuser, 0);
    chk({tag, " sync_err"}, b0.sync_err_out, 0);
    chk({tag, " fft_tready"}, b0.fft_axis_tready, 1);
  endtask

  always @(posedge clk) begin
    #1;
    if (hold_cnt > 0) begin b0.csi_axis_tready = 1'b0; hold_cnt--; end
    else b0.csi_axis_tready = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) prev_hold = 0;
    else begin
      chk("fft_tready rule", b0.fft_axis_tready, b0.csi_axis_tready || !b0.csi_axis_tvalid);
      chk("sync_err", b0.sync_err_out, err_evt);
      if (b0.sync_err_out) n_err++;
      err_evt = 0;
      if (prev_hold)
        chk("held beat stable", {b0.csi_axis_tvalid, b0.csi_axis_tlast, b0.csi_axis_tuser,
                                 b0.csi_re_axis_tdata, b0.csi_im_axis_tdata}, p_snap);
      if (b0.csi_axis_tvalid) begin
        chk("csi beat expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          chk("csi tuser", b0.csi_axis_tuser, q[0].k);
          chk("csi re", b0.csi_re_axis_tdata, q[0].re);
          chk("csi im", b0.csi_im_axis_tdata, q[0].im);
          chk("csi tlast", b0.csi_axis_tlast, q[0].last);
          if (b0.csi_axis_tready) begin
            seen[q[0].k]++; got_re[q[0].k] = q[0].re; got_im[q[0].k] = q[0].im;
            got_re[q[0].k] = b0.csi_re_axis_tdata; got_im[q[0].k] = b0.csi_im_axis_tdata;
            n_beats++;
            void'(q.pop_front());
          end
        end
      end
      prev_hold = b0.csi_axis_tvalid && !b0.csi_axis_tready;
      p_snap = {b0.csi_axis_tvalid, b0.csi_axis_tlast, b0.csi_axis_tuser,
                b0.csi_re_axis_tdata, b0.csi_im_axis_tdata};
    end
  end

  always @(negedge clk) begin
    if (rst_n && b1.csi_axis_tvalid) begin
      seen1[b1.csi_axis_tuser]++;
      got1_re[b1.csi_axis_tuser] = b1.csi_re_axis_tdata;
      got1_im[b1.csi_axis_tuser] = b1.csi_im_axis_tdata;
      if (b1.csi_axis_tlast) begin n_last1++; last1_k = b1.csi_axis_tuser; end
    end
    if (rst_n && b1.sync_err_out) n_err1++;
  end

  initial begin
    int len, s1re, s1im;
    b0.fft_axis_tvalid = 0; b0.fft_axis_tlast = 0; b0.fft_re_axis_tdata = 0; b0.fft_im_axis_tdata = 0;
    b1.fft_axis_tvalid = 0; b1.fft_axis_tlast = 0; b1.fft_re_axis_tdata = 0; b1.fft_im_axis_tdata = 0;
    b1.csi_axis_tready = 1'b1;
    last_k = 0;
    for (int k = 0; k < FL; k++) if (sgn(k) != 0) last_k = k;
    for (int k = 0; k < FL; k++) begin seen1[k] = 0; got1_re[k] = 0; got1_im[k] = 0; end
    chk("model mean 150/2", expv(150, 2, 1), 75);
    chk("model floor -1/2", expv(-1, 2, 1), -1);
    chk("model neg sat", expv(-65536, 2, -1), 32767);
    chk("model last non-null k", last_k, 63);
    model_reset(); clear_seen();

    repeat (3) @(posedge clk);
    @(negedge clk); reset_outputs_zero("in reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("fft_tready after release", b0.fft_axis_tready, 1);
    @(posedge clk); #1;

    // Basic averaging and sign removal
    fill_rand(); clear_seen();
    fr_re[0][1] = 100; fr_re[1][1] = 50; fr_im[0][1] = -20; fr_im[1][1] = -40;
    fr_re[0][2] = 100; fr_re[1][2] = 50;
    send_frame(1); drain();
    chk("k1 re", got_re[1], 75);
    chk("k1 im", got_im[1], -30);
    chk("k2 re", got_re[2], -75);
    chk("k0 null no beat", seen[0], 0);
    chk("beats per frame", n_beats, 52);

    // Floor rounding and saturation
    fill_rand(); clear_seen();
    fr_re[0][1] = 1;      fr_re[1][1] = 0;
    fr_re[0][4] = -1;     fr_re[1][4] = 0;
    fr_re[0][2] = -32768; fr_re[1][2] = -32768;
    send_frame(1); drain();
    chk("k1 re 1/0", got_re[1], 0);
    chk("k4 re -1/0", got_re[4], -1);
    chk("k2 re sat", got_re[2], 32767);

    // Early tlast aborts the frame
    clear_seen();
    for (int k = 0; k <= 10; k++) send0(rnd16(), rnd16(), k == 10);
    repeat (4) @(posedge clk); #1;
    chk("sync_err pulses", n_err, 1);
    chk("no csi for aborted frame", n_beats, 0);
    fill_rand(); clear_seen(); send_frame(1); drain();
    chk("beats after abort", n_beats, 52);

    // 10-cycle downstream stall mid-stream
    fill_rand(); clear_seen();
    fork
      send_frame(1);
      begin repeat (90) @(posedge clk); hold_cnt = 10; end
    join
    drain();
    chk("beats with stall", n_beats, 52);

    // Random backpressure, aborts, and a frame with missing tlast
    bp_rand = 1;
    fill_rand(); clear_seen(); send_frame(0); drain();
    chk("missing tlast tolerated", n_err, 0);
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        len = $urandom_range(1, 100);
        for (int i = 0; i < len; i++) send0(rnd16(), rnd16(), i == len - 1);
      end else begin
        fill_rand(); send_frame(1);
      end
      drain();
    end

    // Asynchronous reset mid-stream
    fill_rand();
    for (int i = 0; i < 80; i++) send0(fr_re[i/64][i%64], fr_im[i/64][i%64], 1'b0);
    rst_n = 1'b0;
    #1 reset_outputs_zero("mid-stream reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fill_rand(); clear_seen(); send_frame(1); drain();
    chk("beats after reset", n_beats, 52);
    chk("model queue empty", q.size(), 0);
    bp_rand = 0;

    // N_LTS=4 instance: one full frame, downstream always ready
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < FL; k++) begin r1_re[s][k] = rnd16(); r1_im[s][k] = rnd16(); end
    r1_re[0][1] = 10; r1_re[1][1] = 20; r1_re[2][1] = 30; r1_re[3][1] = 41;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < FL; k++) begin
        b1.fft_re_axis_tdata = 16'(r1_re[s][k]);
        b1.fft_im_axis_tdata = 16'(r1_im[s][k]);
        b1.fft_axis_tlast    = (s == 3 && k == FL-1);
        b1.fft_axis_tvalid   = 1'b1;
        @(negedge clk); chk("n4 fft_tready", b1.fft_axis_tready, 1);
        @(posedge clk); #1;
      end
    b1.fft_axis_tvalid = 1'b0;
    repeat (4) @(posedge clk); #1;
    for (int k = 0; k < FL; k++) begin
      if (sgn(k) == 0) chk("n4 null no beat", seen1[k], 0);
      else begin
        s1re = 0; s1im = 0;
        for (int s = 0; s < 4; s++) begin s1re += r1_re[s][k]; s1im += r1_im[s][k]; end
        chk("n4 one beat", seen1[k], 1);
        chk("n4 re", got1_re[k], expv(s1re, 4, sgn(k)));
        chk("n4 im", got1_im[k], expv(s1im, 4, sgn(k)));
      end
    end
    chk("n4 k1 re", got1_re[1], 25);
    chk("n4 tlast count", n_last1, 1);
    chk("n4 tlast k", last1_k, 63);
    chk("n4 sync_err", n_err1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
